// File: rtl/bank_mux_rw.sv
// bank_mux_rw: parametrised single-clock data bank.
// NSRC muxed write sources with a per-granule write mask, one broadcast read
// port with 1- or 2-cycle latency, write-first same-address forwarding and a
// hardware sequencer that clears every word of the bank.
module bank_mux_rw #(
  parameter int W     = 64,
  parameter int A     = 10,
  parameter int NSRC  = 3,
  parameter int G     = 8,
  parameter int RDLAT = 1,
  localparam int DEPTH = 2 ** A,
  localparam int S     = $clog2(NSRC),
  localparam int M     = W / G
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [A-1:0]      rd_addr,
  output logic              rd_vld,
  output logic [W-1:0]      rd_word,
  input  logic              wr_en,
  input  logic [A-1:0]      wr_addr,
  input  logic [S-1:0]      wr_muxcode,
  input  logic [NSRC*W-1:0] wr_words,
  input  logic [M-1:0]      wr_mask,
  output logic              wr_err,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam logic [0:0]   ST_IDLE  = 1'b0;
  localparam logic [0:0]   ST_CLEAR = 1'b1;
  localparam logic [A-1:0] CNT_LAST = {A{1'b1}};
  localparam logic [S:0]   NSRC_C   = (S + 1)'(NSRC);

  // Replace the granules selected by mask in old_w with those of new_w.
  function automatic logic [W-1:0] merge_granules(input logic [W-1:0] old_w,
                                                  input logic [W-1:0] new_w,
                                                  input logic [M-1:0] mask);
    logic [W-1:0] res;
    res = old_w;
    for (int j = 0; j < M; j++) begin
      if (mask[j]) begin
        res[j*G +: G] = new_w[j*G +: G];
      end else begin
        res[j*G +: G] = old_w[j*G +: G];
      end
    end
    return res;
  endfunction

  logic [W-1:0] mem_r [DEPTH];
  logic [0:0]   state_r;
  logic [0:0]   state_nxt_s;
  logic [A-1:0] cnt_r;
  logic         wr_err_r;
  logic         code_ok_s;
  logic         wr_take_s;
  logic         wr_drop_s;
  logic         clr_we_s;
  logic [W-1:0] wr_src_s;
  logic [W-1:0] rd_fwd_s;
  logic         rd_vld1_r;
  logic [W-1:0] rd_word1_r;

  // Select the write source as an AND-OR mux; out-of-range codes yield zero
  // but are never written because code_ok_s blocks them.
  always_comb begin
    wr_src_s = {W{1'b0}};
    for (int k = 0; k < NSRC; k++) begin
      wr_src_s = wr_src_s | ({W{wr_muxcode == S'(k)}} & wr_words[k*W +: W]);
    end
  end

  // Write acceptance: only in IDLE (which includes the clr_req cycle) with a
  // valid source code; reset suppresses every memory update, including the
  // clear write of the cycle in which a clear is aborted.
  always_comb begin
    code_ok_s = ({1'b0, wr_muxcode} < NSRC_C);
    wr_take_s = wr_en && code_ok_s && (state_r == ST_IDLE) && !rst;
    wr_drop_s = wr_en && (!code_ok_s || (state_r != ST_IDLE));
    clr_we_s  = (state_r == ST_CLEAR) && !rst;
  end

  // Clear sequencer next-state: IDLE -> CLEAR on request, back after the last word.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state and clear address; the counter idles at zero so CLEAR starts at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {A{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_CLEAR) begin
        cnt_r <= cnt_r + {{(A-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= {A{1'b0}};
      end
    end
  end

  // One-cycle error pulse for an invalid source code or a write dropped during CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= wr_drop_s;
    end
  end

  // Storage update; contents are deliberately not reset. Clear and external
  // writes never coincide because external writes are only taken in IDLE.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[cnt_r] <= {W{1'b0}};
    end else if (wr_take_s) begin
      mem_r[wr_addr] <= merge_granules(mem_r[wr_addr], wr_src_s, wr_mask);
    end
  end

  // Write-first read data: a same-cycle write to the read address is merged in.
  always_comb begin
    rd_fwd_s = mem_r[rd_addr];
    if (clr_we_s && (cnt_r == rd_addr)) begin
      rd_fwd_s = {W{1'b0}};
    end else if (wr_take_s && (wr_addr == rd_addr)) begin
      rd_fwd_s = merge_granules(mem_r[rd_addr], wr_src_s, wr_mask);
    end else begin
      rd_fwd_s = mem_r[rd_addr];
    end
  end

  // First read stage; data holds its last value when no read was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld1_r  <= 1'b0;
      rd_word1_r <= {W{1'b0}};
    end else begin
      rd_vld1_r <= rd_en;
      if (rd_en) begin
        rd_word1_r <= rd_fwd_s;
      end else begin
        rd_word1_r <= rd_word1_r;
      end
    end
  end

  generate
    if (RDLAT == 2) begin : g_lat2
      logic         rd_vld2_r;
      logic [W-1:0] rd_word2_r;

      // Optional output register stage, holding data while nothing is valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_vld2_r  <= 1'b0;
          rd_word2_r <= {W{1'b0}};
        end else begin
          rd_vld2_r <= rd_vld1_r;
          if (rd_vld1_r) begin
            rd_word2_r <= rd_word1_r;
          end else begin
            rd_word2_r <= rd_word2_r;
          end
        end
      end

      assign rd_vld  = rd_vld2_r;
      assign rd_word = rd_word2_r;
    end else begin : g_lat1
      assign rd_vld  = rd_vld1_r;
      assign rd_word = rd_word1_r;
    end
  endgenerate

  assign wr_err   = wr_err_r;
  assign clr_busy = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_bank_mux_rw.sv
// Scoreboard bench for bank_mux_rw: two instances (RDLAT=1 and RDLAT=2, A=4)
// receive identical directed stimulus; expected read data, error pulses and
// clear-busy run lengths are queued at issue time and popped by monitors.
module tb_bank_mux_rw;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [1:0]   wr_muxcode;
  logic [191:0] wr_words;
  logic [7:0]   wr_mask;
  logic         clr_req;

  logic         rd_vld1, rd_vld2;
  logic [63:0]  rd_word1, rd_word2;
  logic         wr_err1, wr_err2;
  logic         clr_busy1, clr_busy2;

  typedef struct {
    int          when;
    logic [63:0] data;
  } rd_exp_t;

  rd_exp_t rq1[$];
  rd_exp_t rq2[$];
  int      eq1[$];
  int      eq2[$];
  int      bq1[$];
  int      bq2[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int bc1     = 0;
  int bc2     = 0;

  logic [63:0] gold [16];

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expectations.
  always @(posedge clk) cyc <= cyc + 1;

  bank_mux_rw #(.W(64), .A(4), .NSRC(3), .G(8), .RDLAT(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_vld(rd_vld1),
    .rd_word(rd_word1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_muxcode(wr_muxcode),
    .wr_words(wr_words), .wr_mask(wr_mask), .wr_err(wr_err1), .clr_req(clr_req),
    .clr_busy(clr_busy1)
  );

  bank_mux_rw #(.W(64), .A(4), .NSRC(3), .G(8), .RDLAT(2)) dut2 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_vld(rd_vld2),
    .rd_word(rd_word2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_muxcode(wr_muxcode),
    .wr_words(wr_words), .wr_mask(wr_mask), .wr_err(wr_err2), .clr_req(clr_req),
    .clr_busy(clr_busy2)
  );

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [63:0] fillv(input int i);
    return 64'h0101_0101_0101_0101 * 64'(i + 1);
  endfunction

  // Monitor for the RDLAT=1 instance.
  always @(negedge clk) begin
    rd_exp_t e;
    int      w;
    if (rd_vld1) begin
      if (rq1.size() == 0) begin
        n_total++;
        $display("FAIL lat1_rd_unexpected: rd_vld high with nothing expected (cycle %0d)", cyc);
      end else begin
        e = rq1.pop_front();
        check("lat1_rd_cycle", 64'(cyc), 64'(e.when));
        check("lat1_rd_data", rd_word1, e.data);
      end
    end
    if (wr_err1) begin
      if (eq1.size() == 0) begin
        n_total++;
        $display("FAIL lat1_wr_err_unexpected: wr_err high with nothing expected (cycle %0d)", cyc);
      end else begin
        w = eq1.pop_front();
        check("lat1_wr_err_cycle", 64'(cyc), 64'(w));
      end
    end
    if (clr_busy1) begin
      bc1++;
    end else if (bc1 != 0) begin
      if (bq1.size() == 0) begin
        n_total++;
        $display("FAIL lat1_busy_unexpected: busy run of %0d cycles not expected", bc1);
      end else begin
        w = bq1.pop_front();
        check("lat1_busy_len", 64'(bc1), 64'(w));
      end
      bc1 = 0;
    end
  end

  // Monitor for the RDLAT=2 instance.
  always @(negedge clk) begin
    rd_exp_t e;
    int      w;
    if (rd_vld2) begin
      if (rq2.size() == 0) begin
        n_total++;
        $display("FAIL lat2_rd_unexpected: rd_vld high with nothing expected (cycle %0d)", cyc);
      end else begin
        e = rq2.pop_front();
        check("lat2_rd_cycle", 64'(cyc), 64'(e.when));
        check("lat2_rd_data", rd_word2, e.data);
      end
    end
    if (wr_err2) begin
      if (eq2.size() == 0) begin
        n_total++;
        $display("FAIL lat2_wr_err_unexpected: wr_err high with nothing expected (cycle %0d)", cyc);
      end else begin
        w = eq2.pop_front();
        check("lat2_wr_err_cycle", 64'(cyc), 64'(w));
      end
    end
    if (clr_busy2) begin
      bc2++;
    end else if (bc2 != 0) begin
      if (bq2.size() == 0) begin
        n_total++;
        $display("FAIL lat2_busy_unexpected: busy run of %0d cycles not expected", bc2);
      end else begin
        w = bq2.pop_front();
        check("lat2_busy_len", 64'(bc2), 64'(w));
      end
      bc2 = 0;
    end
  end

  // Drive one cycle of stimulus (called at a negedge) and queue its expectations.
  task automatic issue(input bit re, input logic [3:0] ra, input logic [63:0] rexp,
                       input bit we, input logic [3:0] wa, input logic [1:0] code,
                       input logic [63:0] wd, input logic [7:0] msk,
                       input bit werr, input bit clr);
    rd_en      = re;
    rd_addr    = ra;
    wr_en      = we;
    wr_addr    = wa;
    wr_muxcode = code;
    wr_mask    = msk;
    clr_req    = clr;
    for (int k = 0; k < 3; k++) begin
      if (int'(code) == k) begin
        wr_words[k*64 +: 64] = wd;
      end else begin
        wr_words[k*64 +: 64] = 64'hDEAD_BEEF_CAFE_F00D ^ {16{4'(k + 1)}};
      end
    end
    if (re) begin
      rq1.push_back('{cyc + 1, rexp});
      rq2.push_back('{cyc + 2, rexp});
    end
    if (werr) begin
      eq1.push_back(cyc + 1);
      eq2.push_back(cyc + 1);
    end
    @(negedge clk);
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] code, input logic [63:0] d,
                    input logic [7:0] msk);
    issue(1'b0, 4'd0, 64'd0, 1'b1, a, code, d, msk, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [63:0] exp_d);
    issue(1'b1, a, exp_d, 1'b0, 4'd0, 2'd0, 64'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      issue(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 2'd0, 64'd0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    rd_en      = 1'b0;
    rd_addr    = 4'd0;
    wr_en      = 1'b0;
    wr_addr    = 4'd0;
    wr_muxcode = 2'd0;
    wr_words   = 192'd0;
    wr_mask    = 8'h00;
    clr_req    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    check("lat1_reset_rd_vld", 64'(rd_vld1), 64'd0);
    check("lat1_reset_rd_word", rd_word1, 64'd0);
    check("lat1_reset_wr_err", 64'(wr_err1), 64'd0);
    check("lat1_reset_clr_busy", 64'(clr_busy1), 64'd0);
    check("lat2_reset_rd_vld", 64'(rd_vld2), 64'd0);
    check("lat2_reset_rd_word", rd_word2, 64'd0);
    check("lat2_reset_wr_err", 64'(wr_err2), 64'd0);
    check("lat2_reset_clr_busy", 64'(clr_busy2), 64'd0);
    rst = 1'b0;

    // Prefill every word through rotating sources.
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 2'(i % 3), fillv(i), 8'hFF);
      gold[i] = fillv(i);
    end

    // Basic write via source 0 then read.
    wr(4'd3, 2'd0, {8{8'hA5}}, 8'hFF);
    gold[3] = {8{8'hA5}};
    rd(4'd3, 64'hA5A5_A5A5_A5A5_A5A5);

    // Masked write of the low four granules from source 2.
    wr(4'd7, 2'd0, 64'h1111_1111_1111_1111, 8'hFF);
    wr(4'd7, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    gold[7] = 64'h1111_1111_FFFF_FFFF;
    rd(4'd7, 64'h1111_1111_FFFF_FFFF);

    // Same-cycle write and read: full word, then a single-granule merge.
    issue(1'b1, 4'd5, 64'h42, 1'b1, 4'd5, 2'd1, 64'h42, 8'hFF, 1'b0, 1'b0);
    issue(1'b1, 4'd5, 64'hEE, 1'b1, 4'd5, 2'd2, 64'hFFFF_FFFF_FFFF_FFEE, 8'h01, 1'b0, 1'b0);
    gold[5] = 64'hEE;

    // Invalid source code: error pulse, memory unchanged even for a same-cycle read.
    issue(1'b1, 4'd7, 64'h1111_1111_FFFF_FFFF, 1'b1, 4'd7, 2'd3, 64'd0, 8'hFF, 1'b1, 1'b0);
    rd(4'd7, 64'h1111_1111_FFFF_FFFF);

    // Zero mask is a silent no-op.
    issue(1'b1, 4'd3, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 4'd3, 2'd1, 64'd0, 8'h00, 1'b0, 1'b0);

    // Back-to-back reads of the whole bank.
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), gold[i]);
    end
    nop(3);

    // Clear: write accepted in the request cycle, dropped write and ignored
    // re-request mid-clear, reads during the clear.
    bq1.push_back(16);
    bq2.push_back(16);
    issue(1'b1, 4'd9, 64'h9999_9999_9999_9999, 1'b1, 4'd9, 2'd0, 64'h9999_9999_9999_9999,
          8'hFF, 1'b0, 1'b1);
    nop(1);
    issue(1'b0, 4'd0, 64'd0, 1'b1, 4'd12, 2'd0, 64'h5555_5555_5555_5555, 8'hFF, 1'b1, 1'b1);
    rd(4'd12, gold[12]);
    nop(1);
    rd(4'd4, 64'd0);
    rd(4'd2, 64'd0);
    nop(11);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 64'd0);
    end
    nop(3);

    // Reset during clear word 6 aborts the sequence.
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 2'(i % 3), fillv(i), 8'hFF);
    end
    bq1.push_back(7);
    bq2.push_back(7);
    issue(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 2'd0, 64'd0, 8'h00, 1'b0, 1'b1);
    nop(6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("lat1_abort_clr_busy", 64'(clr_busy1), 64'd0);
    check("lat2_abort_clr_busy", 64'(clr_busy2), 64'd0);
    nop(1);
    for (int i = 0; i < 16; i++) begin
      if (i < 6) begin
        rd(4'(i), 64'd0);
      end else begin
        rd(4'(i), fillv(i));
      end
    end
    nop(4);

    // Every queued expectation must have been consumed.
    check("lat1_rd_queue_drained", 64'(rq1.size()), 64'd0);
    check("lat2_rd_queue_drained", 64'(rq2.size()), 64'd0);
    check("lat1_err_queue_drained", 64'(eq1.size()), 64'd0);
    check("lat2_err_queue_drained", 64'(eq2.size()), 64'd0);
    check("lat1_busy_queue_drained", 64'(bq1.size()), 64'd0);
    check("lat2_busy_queue_drained", 64'(bq2.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
